serial_alu_engine: RTL and testbench

Digit-serial RV32E ALU engine that processes operands NIB bits per cycle, LSB digit first, behind a start/done handshake. It is the parametrised successor of the fixed 4-bit-per-cycle ALU loop: width and digit size are configurable, operands are latched at start, and equality compares are supported. It sits between the decoder/register-file read path and the writeback mux of the minimal-area core.

---
 rtl/serial_alu_pkg.sv | 24 ++
 rtl/serial_alu_digit.sv | 30 +++
 rtl/serial_alu_engine.sv | 90 +++++++++
 tb/tb_serial_alu_engine.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: op codes, FSM state codes and op-class helpers for the serial ALU
package serial_alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1100;
  localparam logic [3:0] OP_NE   = 4'b1101;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  function automatic logic is_sub(input logic [3:0] op);
    return op inside {OP_SUB, OP_SLT, OP_SLTU, OP_EQ, OP_NE};
  endfunction
  function automatic logic is_cmp(input logic [3:0] op);
    return op inside {OP_SLT, OP_SLTU, OP_EQ, OP_NE};
  endfunction
  function automatic logic is_logic(input logic [3:0] op);
    return op inside {OP_XOR, OP_OR, OP_AND};
  endfunction
endpackage

// File: rtl/serial_alu_digit.sv
// serial_alu_digit: one NIB-wide slice of the add/sub/logic/equality datapath
module serial_alu_digit
  import serial_alu_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic [3:0]     op,
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  input  logic           eq_in,
  output logic [NIB-1:0] r,
  output logic           cout,
  output logic           eq_out,
  output logic           slt
);
  logic [NIB-1:0] bx;
  logic [NIB:0]   sum;
  logic           ovf;
  // digit add with optional B inversion; slt is only meaningful on the MSB digit
  always_comb begin
    bx = is_sub(op) ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{NIB{1'b0}}, cin};
    ovf = (a[NIB-1] == bx[NIB-1]) && (sum[NIB-1] != a[NIB-1]);
    r = op == OP_XOR ? a ^ b : op == OP_OR ? a | b : op == OP_AND ? a & b : sum[NIB-1:0];
    cout = sum[NIB];
    eq_out = eq_in && (a == b);
    slt = sum[NIB-1] ^ ovf;
  end
endmodule

// File: rtl/serial_alu_engine.sv
// serial_alu_engine: digit-serial RV32E ALU, LSB digit first, start/done handshake
module serial_alu_engine
  import serial_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NIB  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] d,
  output logic            cmp
);
  localparam int N  = XLEN / NIB;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  logic [1:0]      state;
  logic [KW-1:0]   k;
  logic [3:0]      op_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;
  logic            carry;
  logic            eq;
  logic            cin;
  logic            eq_in;
  logic            last;
  logic            flag;
  logic [NIB-1:0]  r;
  logic            cout;
  logic            eq_out;
  logic            slt;
  assign busy  = state == S_RUN;
  assign done  = state == S_DONE;
  assign last  = k == KW'(N - 1);
  assign cin   = k == '0 ? is_sub(op_r) : carry;
  assign eq_in = k == '0 || eq;
  serial_alu_digit #(.NIB(NIB)) u_digit (
    .op(op_r),
    .a(a_r[NIB-1:0]),
    .b(b_r[NIB-1:0]),
    .cin(cin),
    .eq_in(eq_in),
    .r(r),
    .cout(cout),
    .eq_out(eq_out),
    .slt(slt)
  );
  // flag reported on the final digit, chosen by op class
  always_comb
    flag = op_r == OP_SLT ? slt : op_r == OP_SLTU ? !cout : op_r == OP_EQ ? eq_out :
           op_r == OP_NE ? !eq_out : is_logic(op_r) ? 1'b0 : cout;
  // FSM, operand shifting, carry/eq chaining and result assembly
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      k     <= '0;
      carry <= 1'b0;
      eq    <= 1'b0;
      d     <= '0;
      cmp   <= 1'b0;
      op_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
    end else if (state != S_RUN) begin
      state <= start ? S_RUN : S_IDLE;
      if (start) begin
        op_r <= op;
        a_r  <= a;
        b_r  <= b;
        k    <= '0;
      end
    end else begin
      a_r   <= a_r >> NIB;
      b_r   <= b_r >> NIB;
      carry <= cout;
      eq    <= eq_out;
      k     <= last ? '0 : k + 1'b1;
      d[k*NIB +: NIB] <= r;
      if (last) begin
        state <= S_DONE;
        cmp   <= flag;
        if (is_cmp(op_r)) d <= XLEN'(flag);
      end
    end
  end
endmodule

// File: tb/tb_serial_alu_engine.sv
// tb_serial_alu_engine: scoreboard bench over NIB=4, NIB=1 and NIB=8 instances
module tb_serial_alu_engine;
  typedef struct {
    logic [31:0] d;
    logic        c;
  } exp_t;
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, SLT = 4'b0010, SLTU = 4'b0011;
  localparam logic [3:0] XOR = 4'b0100, OR = 4'b0110, AND = 4'b0111, EQ = 4'b1100, NE = 4'b1101;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  start = '0;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  cmp;
  logic [31:0] d [3];
  exp_t        sb[$];
  int          lat_exp[3] = '{9, 33, 5};
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  serial_alu_engine #(.XLEN(32), .NIB(4)) dut4 (.clk(clk), .rstn(rstn), .start(start[0]), .op(op), .a(a), .b(b),
    .busy(busy[0]), .done(done[0]), .d(d[0]), .cmp(cmp[0]));
  serial_alu_engine #(.XLEN(32), .NIB(1)) dut1 (.clk(clk), .rstn(rstn), .start(start[1]), .op(op), .a(a), .b(b),
    .busy(busy[1]), .done(done[1]), .d(d[1]), .cmp(cmp[1]));
  serial_alu_engine #(.XLEN(32), .NIB(8)) dut8 (.clk(clk), .rstn(rstn), .start(start[2]), .op(op), .a(a), .b(b),
    .busy(busy[2]), .done(done[2]), .d(d[2]), .cmp(cmp[2]));
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    logic [32:0] p;
    logic        lt;
    exp_t        e;
    s = {1'b0, x} + {1'b0, ~y} + 33'd1;
    p = {1'b0, x} + {1'b0, y};
    e.d = p[31:0];
    e.c = p[32];
    case (o)
      SUB:  begin e.d = s[31:0]; e.c = s[32]; end
      SLT:  begin lt = $signed(x) < $signed(y); e.d = {31'b0, lt}; e.c = lt; end
      SLTU: begin lt = x < y; e.d = {31'b0, lt}; e.c = lt; end
      EQ:   begin lt = x == y; e.d = {31'b0, lt}; e.c = lt; end
      NE:   begin lt = x != y; e.d = {31'b0, lt}; e.c = lt; end
      XOR:  begin e.d = x ^ y; e.c = 1'b0; end
      OR:   begin e.d = x | y; e.c = 1'b0; end
      AND:  begin e.d = x & y; e.c = 1'b0; end
      default: ;
    endcase
    return e;
  endfunction
  task automatic issue(input int i, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start[i] = 1'b1;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start[i] = 1'b0;
  endtask
  task automatic wait_done(input int i, input int l0, output int lat);
    lat = l0;
    while (!done[i] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b0 || d[i] !== 32'h0 || cmp[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset[%0d]: got busy=%b done=%b d=%h cmp=%b, want 0 0 00000000 0", i, busy[i], done[i], d[i], cmp[i]);
      end
    end
    rstn = 1'b1;
  endtask
  task automatic test_ops();
    logic [3:0]  to[12] = '{ADD, SUB, SLTU, SLT, SLTU, EQ, NE, OR, SLT, NE, EQ, 4'b1111};
    logic [31:0] tx[12] = '{32'hFFFFFFFF, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h12345678,
                            32'h12345678, 32'hF0F00000, 32'h7FFFFFFF, 32'd5, 32'd1, 32'hFFFFFFFF};
    logic [31:0] ty[12] = '{32'h1, 32'd7, 32'd7, 32'h1, 32'h1, 32'h12345678,
                            32'h12345679, 32'h0000F0F0, 32'h80000000, 32'd5, 32'd2, 32'h2};
    logic [3:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
    exp_t        e;
    for (int j = 0; j < 36; j++) begin
      if (j < 12) begin
        o = to[j]; x = tx[j]; y = ty[j];
      end else begin
        o = 4'($urandom_range(0, 15)); x = $urandom; y = $urandom;
      end
      issue(0, o, x, y);
      wait_done(0, 1, lat);
      e = sb.pop_front();
      n_cmp++;
      if (lat != 9 || d[0] !== e.d || cmp[0] !== e.c) begin
        n_bad++;
        $display("FAIL ops[%0d] op=%b a=%h b=%h: got d=%h cmp=%b lat=%0d, want d=%h cmp=%b lat=9", j, o, x, y, d[0], cmp[0], lat, e.d, e.c);
      end
    end
  endtask
  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    issue(0, XOR, 32'hF0F0F0F0, 32'hFFFF0000);
    wait_done(0, 1, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 9 || d[0] !== e.d || d[0] !== 32'h0F0FF0F0) begin
      n_bad++;
      $display("FAIL b2b_xor: got d=%h lat=%0d, want d=0f0ff0f0 lat=9", d[0], lat);
    end
    op = AND;
    a = 32'h3C3C00FF;
    b = 32'hFF0F0F0F;
    start[0] = 1'b1;
    sb.push_back(model(AND, 32'h3C3C00FF, 32'hFF0F0F0F));
    @(negedge clk);
    start[0] = 1'b0;
    n_cmp++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_restart: got done=%b busy=%b, want done=0 busy=1", done[0], busy[0]);
    end
    wait_done(0, 1, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 9 || d[0] !== e.d || cmp[0] !== e.c) begin
      n_bad++;
      $display("FAIL b2b_and: got d=%h cmp=%b lat=%0d, want d=%h cmp=%b lat=9", d[0], cmp[0], lat, e.d, e.c);
    end
    @(negedge clk);
    n_cmp++;
    if (done[0] !== 1'b0 || d[0] !== e.d || cmp[0] !== e.c) begin
      n_bad++;
      $display("FAIL hold: got done=%b d=%h cmp=%b, want done=0 d=%h cmp=%b", done[0], d[0], cmp[0], e.d, e.c);
    end
  endtask
  task automatic test_start_ignored();
    int   lat;
    exp_t e;
    issue(0, ADD, 32'h11111111, 32'h22222222);
    repeat (3) @(negedge clk);
    op = SUB;
    a = 32'hDEADBEEF;
    b = 32'h01234567;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 5, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 9 || d[0] !== e.d || d[0] !== 32'h33333333 || cmp[0] !== e.c) begin
      n_bad++;
      $display("FAIL start_ignored: got d=%h cmp=%b lat=%0d, want d=33333333 cmp=%b lat=9", d[0], cmp[0], lat, e.c);
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (busy[0] !== 1'b0 || d[0] !== 32'h33333333) begin
      n_bad++;
      $display("FAIL no_queue: got busy=%b d=%h, want busy=0 d=33333333", busy[0], d[0]);
    end
  endtask
  task automatic test_mid_reset();
    int   lat;
    int   seen;
    exp_t e;
    issue(0, ADD, 32'hFFFFFFFF, 32'h1);
    wait_done(0, 1, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 9 || d[0] !== 32'h0 || cmp[0] !== 1'b1 || e.c !== 1'b1) begin
      n_bad++;
      $display("FAIL add_carry: got d=%h cmp=%b lat=%0d, want d=00000000 cmp=1 lat=9", d[0], cmp[0], lat);
    end
    issue(0, ADD, 32'h12345678, 32'h11111111);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || d[0] !== 32'h0 || cmp[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got busy=%b done=%b d=%h cmp=%b, want 0 0 00000000 0", busy[0], done[0], d[0], cmp[0]);
    end
    rstn = 1'b1;
    sb.delete();
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done[0] || busy[0]) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %0d active cycles, want 0", seen);
    end
  endtask
  task automatic test_nib_variants();
    logic [3:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
    exp_t        e;
    for (int i = 1; i < 3; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (j == 0) begin
          o = ADD; x = 32'hFFFFFFFF; y = 32'h1;
        end else begin
          o = 4'($urandom_range(0, 15)); x = $urandom; y = (j == 1) ? x : $urandom;
        end
        issue(i, o, x, y);
        wait_done(i, 1, lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat != lat_exp[i] || d[i] !== e.d || cmp[i] !== e.c) begin
          n_bad++;
          $display("FAIL nib[%0d][%0d] op=%b a=%h b=%h: got d=%h cmp=%b lat=%0d, want d=%h cmp=%b lat=%0d",
                   i, j, o, x, y, d[i], cmp[i], lat, e.d, e.c, lat_exp[i]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_start_ignored();
    test_mid_reset();
    test_nib_variants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
